fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/arm_pkg.sv | 8 +
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit_fifo.sv | 48 ++++
 rtl/fetch_unit.sv | 61 ++++++
 4 files changed

// File: rtl/arm_pkg.sv
// arm_pkg: shared fetch constants and prefetch buffer entry type
package arm_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory bus, decode handshake and redirect signals
interface fetch_unit_if;
    logic        PCSrc;
    logic [31:0] Result;
    logic        IReq;
    logic [31:0] IAddr;
    logic        IGnt;
    logic        IRValid;
    logic [31:0] IRData;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] PCPlus8;
    modport master (
        input  PCSrc, Result, IGnt, IRValid, IRData, InstrReady,
        output IReq, IAddr, Instr, InstrValid, PCPlus8
    );
    modport slave (
        output PCSrc, Result, IGnt, IRValid, IRData, InstrReady,
        input  IReq, IAddr, Instr, InstrValid, PCPlus8
    );
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: circular prefetch buffer with synchronous flush
module fetch_fifo
    import arm_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          empty,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign head    = mem[rd];

    // storage write; slots outside rd..wr are don't-care so no reset is needed
    always_ff @(posedge clk)
        if (do_push) mem[wr] <= din;

    // pointers and occupancy; flush empties the buffer in one cycle
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= nxt(wr);
            if (do_pop) rd <= nxt(rd);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: prefetching fetch stage with in-order response tracking and redirect drain
module fetch_unit
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2,
    localparam int         CW       = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    logic [31:0]   fpc, rpc;
    logic [CW-1:0] outst, outst_n, drop, count;
    logic          xfer, rv, pop, redir, push, empty;
    fetch_entry_t  head, din;

    assign xfer    = bus.IReq && bus.IGnt;
    assign rv      = bus.IRValid && outst != '0;
    assign pop     = bus.InstrValid && bus.InstrReady;
    assign redir   = pop && bus.PCSrc;
    assign push    = rv && drop == '0 && !redir;
    assign outst_n = outst + CW'(xfer) - CW'(rv);
    assign din     = '{instr: bus.IRData, pc: rpc};

    assign bus.IReq       = !reset && (count + outst) < CW'(DEPTH);
    assign bus.IAddr      = fpc;
    assign bus.InstrValid = !reset && !empty;
    assign bus.Instr      = head.instr;
    assign bus.PCPlus8    = head.pc + 32'd8;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redir),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .empty (empty),
        .count (count)
    );

    // fpc tracks requests, rpc tracks the address of the next kept response
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc   <= RESET_PC;
            rpc   <= RESET_PC;
            outst <= '0;
            drop  <= '0;
        end else begin
            fpc   <= redir ? (bus.Result & 32'hFFFF_FFFC) : xfer ? fpc + 32'd4 : fpc;
            rpc   <= redir ? (bus.Result & 32'hFFFF_FFFC) : push ? rpc + 32'd4 : rpc;
            outst <= outst_n;
            drop  <= redir ? outst_n : drop - CW'(rv && drop != '0);
        end
    end

    // a response with nothing outstanding is a memory protocol violation
    assert property (@(posedge clk) disable iff (reset) !(bus.IRValid && outst == '0));
endmodule
